// File: rtl/time_set_ctrl.sv
// Front-panel time-entry controller: debounces three keys, edits an hh:mm:ss BCD
// working copy field by field, and issues a one-cycle commit strobe.
module time_set_ctrl #(
  parameter int DB_CYC      = 50000,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_ok,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       set_time_finish,
  output logic       editing,
  output logic [2:0] edit_field
);

  localparam int DBW = $clog2(DB_CYC);
  localparam int TOW = $clog2(TIMEOUT_CYC);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYC - 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // BCD hour increment with 23 -> 00 wrap.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD minute/second increment with 59 -> 00 wrap.
  function automatic logic [7:0] inc_ms(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {((v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Key bit order: [2]=ok, [1]=mode, [0]=inc.
  logic [2:0]     raw_s;
  logic [2:0]     sync1_r, sync2_r, db_r, db_d_r, press_r;
  logic [DBW-1:0] db_cnt_r [3];

  assign raw_s = {key_ok, key_mode, key_inc};

  // Synchronize, debounce and turn debounced rising edges into press pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      db_r    <= 3'b000;
      db_d_r  <= 3'b000;
      press_r <= 3'b000;
      for (int k = 0; k < 3; k++) db_cnt_r[k] <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      press_r <= db_r & ~db_d_r;
      for (int k = 0; k < 3; k++) begin
        if (sync2_r[k] == db_r[k]) begin
          db_cnt_r[k] <= '0;
        end else if (db_cnt_r[k] == DB_MAX) begin
          db_r[k]     <= sync2_r[k];
          db_cnt_r[k] <= '0;
        end else begin
          db_cnt_r[k] <= db_cnt_r[k] + DBW'(1);
        end
      end
    end
  end

  logic   ok_ev_s, mode_ev_s, inc_ev_s, any_ev_s, is_edit_s, timeout_s;
  logic   next_editing_s;
  logic [2:0] next_field_s;
  state_t state_r, next_state_s;
  logic [TOW-1:0] to_cnt_r;
  logic [7:0] hour_r, min_r, sec_r, sh_hour_r, sh_min_r, sh_sec_r;

  assign ok_ev_s   = press_r[2];
  assign mode_ev_s = press_r[1] & ~press_r[2];
  assign inc_ev_s  = press_r[0] & ~press_r[1] & ~press_r[2];
  assign any_ev_s  = |press_r;
  assign is_edit_s = (state_r == ST_EDIT_H) || (state_r == ST_EDIT_M) || (state_r == ST_EDIT_S);
  // A press in the same cycle as expiry keeps the edit alive.
  assign timeout_s = is_edit_s && (to_cnt_r == TO_MAX) && !any_ev_s;

  // Next-state and registered-output decode.
  always_comb begin
    next_state_s   = state_r;
    next_editing_s = 1'b0;
    next_field_s   = 3'b000;
    case (state_r)
      ST_IDLE: begin
        if (mode_ev_s) next_state_s = ST_EDIT_H;
        else next_state_s = ST_IDLE;
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        if (ok_ev_s) begin
          next_state_s = ST_COMMIT;
        end else if (mode_ev_s) begin
          if (state_r == ST_EDIT_H) next_state_s = ST_EDIT_M;
          else if (state_r == ST_EDIT_M) next_state_s = ST_EDIT_S;
          else next_state_s = ST_EDIT_H;
        end else if (timeout_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
    case (next_state_s)
      ST_EDIT_H: begin next_editing_s = 1'b1; next_field_s = 3'b100; end
      ST_EDIT_M: begin next_editing_s = 1'b1; next_field_s = 3'b010; end
      ST_EDIT_S: begin next_editing_s = 1'b1; next_field_s = 3'b001; end
      default:   begin next_editing_s = 1'b0; next_field_s = 3'b000; end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      editing         <= 1'b0;
      edit_field      <= 3'b000;
      set_time_finish <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      editing         <= next_editing_s;
      edit_field      <= next_field_s;
      set_time_finish <= (next_state_s == ST_COMMIT);
    end
  end

  // Saturating idle counter for abandoning an edit.
  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_r <= '0;
    else if (!is_edit_s || any_ev_s) to_cnt_r <= '0;
    else if (to_cnt_r != TO_MAX) to_cnt_r <= to_cnt_r + TOW'(1);
    else to_cnt_r <= to_cnt_r;
  end

  // Working copy edits and shadow snapshot/revert.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hour_r <= 8'h12; min_r <= 8'h00; sec_r <= 8'h00;
      sh_hour_r <= 8'h12; sh_min_r <= 8'h00; sh_sec_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mode_ev_s) begin
            sh_hour_r <= hour_r; sh_min_r <= min_r; sh_sec_r <= sec_r;
          end
        end
        ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
          if (inc_ev_s) begin
            if (state_r == ST_EDIT_H) hour_r <= inc_hour(hour_r);
            else if (state_r == ST_EDIT_M) min_r <= inc_ms(min_r);
            else sec_r <= inc_ms(sec_r);
          end else if (timeout_s) begin
            hour_r <= sh_hour_r; min_r <= sh_min_r; sec_r <= sh_sec_r;
          end
        end
        ST_COMMIT: begin
          sh_hour_r <= hour_r; sh_min_r <= min_r; sh_sec_r <= sec_r;
        end
        default: begin
          hour_r <= sh_hour_r; min_r <= sh_min_r; sec_r <= sh_sec_r;
        end
      endcase
    end
  end

  assign {set_hour_shi, set_hour_ge} = hour_r;
  assign {set_min_shi, set_min_ge}   = min_r;
  assign {set_sec_shi, set_sec_ge}   = sec_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with DB_CYC=4, TIMEOUT_CYC=64.
module tb_time_set_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_mode = 1'b0, key_inc = 1'b0, key_ok = 1'b0;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic set_time_finish, editing;
  logic [2:0] edit_field;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_total = 0;
  int strobe_run = 0;
  int strobe_max_run = 0;
  logic [23:0] strobe_val = 24'h0;

  time_set_ctrl #(.DB_CYC(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode(key_mode), .key_inc(key_inc), .key_ok(key_ok),
    .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
    .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
    .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
    .set_time_finish(set_time_finish), .editing(editing), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] cur_time();
    return {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Strobe monitor: counts pulses, their width and the time presented with them.
  always @(negedge clk) begin
    if (set_time_finish === 1'b1) begin
      strobe_total = strobe_total + 1;
      strobe_val = cur_time();
      strobe_run = strobe_run + 1;
      if (strobe_run > strobe_max_run) strobe_max_run = strobe_run;
    end else begin
      strobe_run = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_ok = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // keys = {ok, mode, inc}
  task automatic press(input logic [2:0] keys);
    @(negedge clk);
    {key_ok, key_mode, key_inc} = keys;
    repeat (10) @(negedge clk);
    {key_ok, key_mode, key_inc} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    @(negedge clk);
    rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_ok = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      obs = {cur_time(), 5'b0, set_time_finish, editing, edit_field};
      n_cmp++;
      if (obs !== {24'h120000, 5'b0, 1'b0, 1'b0, 3'b000}) begin
        n_bad++;
        $display("FAIL reset_state cycle %0d: got %h required %h", i, obs, {24'h120000, 10'h000});
      end
    end
  endtask

  task automatic test_hour_wrap();
    int s0;
    logic [7:0] exp_h;
    do_reset();
    press(3'b010);
    n_cmp++;
    if ({editing, edit_field} !== 4'b1100) begin
      n_bad++; $display("FAIL hour_field: got %b required 1100", {editing, edit_field});
    end
    for (int i = 1; i <= 12; i++) begin
      press(3'b001);
      exp_h = to_bcd((12 + i) % 24);
      n_cmp++;
      if (cur_time() !== {exp_h, 16'h0000}) begin
        n_bad++; $display("FAIL hour_inc %0d: got %h required %h", i, cur_time(), {exp_h, 16'h0000});
      end
    end
    s0 = strobe_total;
    press(3'b100);
    n_cmp++;
    if (strobe_total - s0 !== 1) begin
      n_bad++; $display("FAIL hour_commit_count: got %0d required 1", strobe_total - s0);
    end
    n_cmp++;
    if (strobe_val !== 24'h000000) begin
      n_bad++; $display("FAIL hour_commit_value: got %h required 000000", strobe_val);
    end
    n_cmp++;
    if (strobe_max_run !== 1) begin
      n_bad++; $display("FAIL strobe_width: got %0d required 1", strobe_max_run);
    end
    n_cmp++;
    if ({editing, edit_field} !== 4'b0000) begin
      n_bad++; $display("FAIL hour_after_commit: got %b required 0000", {editing, edit_field});
    end
  endtask

  task automatic test_min_carry();
    int s0;
    logic [7:0] exp_m;
    do_reset();
    press(3'b010);
    press(3'b010);
    n_cmp++;
    if (edit_field !== 3'b010) begin
      n_bad++; $display("FAIL min_field: got %b required 010", edit_field);
    end
    for (int i = 1; i <= 60; i++) begin
      press(3'b001);
      exp_m = to_bcd(i % 60);
      n_cmp++;
      if (cur_time() !== {8'h12, exp_m, 8'h00}) begin
        n_bad++; $display("FAIL min_inc %0d: got %h required %h", i, cur_time(), {8'h12, exp_m, 8'h00});
      end
    end
    s0 = strobe_total;
    press(3'b100);
    n_cmp++;
    if (strobe_total - s0 !== 1 || strobe_val !== 24'h120000) begin
      n_bad++; $display("FAIL min_commit: got %0d strobes value %h required 1 strobe 120000",
                        strobe_total - s0, strobe_val);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    press(3'b010);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_inc = ((i / 2) % 2 == 0);
    end
    @(negedge clk);
    key_inc = 1'b0;
    @(negedge clk);
    key_inc = 1'b0;
    n_cmp++;
    if (cur_time() !== 24'h120000) begin
      n_bad++; $display("FAIL bounce_no_event: got %h required 120000", cur_time());
    end
    @(negedge clk);
    key_inc = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (cur_time() !== 24'h120000) begin
      n_bad++; $display("FAIL debounce_early: got %h required 120000", cur_time());
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (cur_time() !== 24'h130000) begin
      n_bad++; $display("FAIL debounce_latency: got %h required 130000", cur_time());
    end
    repeat (13) @(negedge clk);
    key_inc = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cur_time() !== 24'h130000) begin
      n_bad++; $display("FAIL no_autorepeat: got %h required 130000", cur_time());
    end
  endtask

  task automatic test_timeout();
    int s0;
    int waited;
    do_reset();
    press(3'b010);
    for (int i = 0; i < 3; i++) press(3'b001);
    n_cmp++;
    if (cur_time() !== 24'h150000) begin
      n_bad++; $display("FAIL timeout_setup: got %h required 150000", cur_time());
    end
    s0 = strobe_total;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (editing !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: got editing %b required 1", editing);
    end
    waited = 0;
    while (editing === 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (editing !== 1'b0) begin
      n_bad++; $display("FAIL timeout_expire: got editing %b required 0 within budget", editing);
    end
    n_cmp++;
    if (cur_time() !== 24'h120000 || edit_field !== 3'b000) begin
      n_bad++; $display("FAIL timeout_revert: got %h field %b required 120000 field 000", cur_time(), edit_field);
    end
    n_cmp++;
    if (strobe_total !== s0) begin
      n_bad++; $display("FAIL timeout_no_strobe: got %0d strobes required 0", strobe_total - s0);
    end
  endtask

  task automatic test_priority_reset();
    int s0;
    do_reset();
    press(3'b010); press(3'b010); press(3'b010);
    n_cmp++;
    if (edit_field !== 3'b001) begin
      n_bad++; $display("FAIL sec_field: got %b required 001", edit_field);
    end
    press(3'b001);
    s0 = strobe_total;
    press(3'b101);
    n_cmp++;
    if (strobe_total - s0 !== 1 || strobe_val !== 24'h120001 || cur_time() !== 24'h120001) begin
      n_bad++; $display("FAIL ok_over_inc: got %0d strobes value %h time %h required 1 strobe 120001",
                        strobe_total - s0, strobe_val, cur_time());
    end
    press(3'b010);
    press(3'b001);
    n_cmp++;
    if (cur_time() !== 24'h130001 || edit_field !== 3'b100) begin
      n_bad++; $display("FAIL reedit_hour: got %h field %b required 130001 field 100", cur_time(), edit_field);
    end
    s0 = strobe_total;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cur_time(), set_time_finish, editing, edit_field} !== {24'h120000, 5'b00000}) begin
      n_bad++; $display("FAIL reset_mid_edit: got %h %b %b %b required 120000 0 0 000",
                        cur_time(), set_time_finish, editing, edit_field);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (strobe_total !== s0 || cur_time() !== 24'h120000) begin
      n_bad++; $display("FAIL reset_no_strobe: got %0d strobes time %h required 0 strobes 120000",
                        strobe_total - s0, cur_time());
    end
  endtask

  initial begin
    test_reset();
    test_hour_wrap();
    test_min_carry();
    test_debounce();
    test_timeout();
    test_priority_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
